lt_cmp_sched: RTL
=================

LT_CMP_SCHED -- requirements
Module: lt_cmp_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the comparator.
REQ-002 Parameter W, default 16: maximum operand width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; a request transfers when valid and ready are both high.
REQ-007 req_a, req_b  input  NREQ x W  operands.
REQ-008 req_awidth, req_bwidth  input  NREQ x 5  operand widths, range 1..W.
REQ-009 req_signed  input  NREQ  1 = both operands signed; 0 = both unsigned.
REQ-010 res_valid  output  1  result valid.
REQ-011 res_ready  input  1  consumer accept.
REQ-012 res_id  output  clog2(NREQ)  index of the originating requester.
REQ-013 res_lt  output  1  comparison result a < b.

Function
REQ-014 Arbitration SHALL be round-robin.
- Priority starts at rr_ptr and proceeds upward with wrap-around.
- After a grant to requester k, rr_ptr becomes (k+1) mod NREQ.
- rr_ptr SHALL NOT change in cycles with no grant.
REQ-015 At most one req_ready bit SHALL be high per cycle.
- That bit belongs to the granted requester.
- It is high only when stage 1 can accept (stage 1 empty, or stage 1 advancing).
REQ-016 req_ready SHALL be computed from req_valid and pipeline state.
- A requester that drops valid without a transfer SHALL lose the grant with no side effect.
REQ-017 Pipeline: two stages, S1 and S2; each holds a valid bit, id and operands.
- Transfer at edge t: the result presents res_valid at cycle t+2 when no stall occurs.
- Sustained throughput: one result per cycle.
REQ-018 S1 (extension): each operand SHALL be masked to bits [width-1:0] and extended to W bits.
- Sign-extended from bit width-1 when req_signed is set.
- Zero-extended otherwise.
- Bits at or above width are ignored.
REQ-019 Width 0 SHALL be treated as W; widths above W SHALL saturate to W.
REQ-020 S2 (compare): res_lt SHALL be the signed comparison of the extended operands when the signed flag is set, unsigned otherwise.
REQ-021 Stall: while res_valid=1 and res_ready=0:
- S2 contents SHALL hold stable.
- S1 advances into S2 only if S2 empties.
- No new grant is issued while S1 is full and blocked.
REQ-022 When S2 is consumed and S1 is full in the same cycle, S1 SHALL move to S2, and a new request MAY enter S1 in that same cycle.
REQ-023 Scheduler FSM, three states:
- IDLE: no valid stage.
- RUN: pipeline moving.
- STALL: S2 valid, res_ready low.
- Transitions: IDLE->RUN on transfer; RUN->STALL on res_valid and !res_ready; STALL->RUN on res_ready; RUN->IDLE when both stages empty after the edge and no transfer occurs.
REQ-024 Ordering: results SHALL be returned in acceptance order. No request is dropped or duplicated.

Reset
REQ-025 With rst high at an edge:
- res_valid=0, both stage valid bits=0, rr_ptr=0, FSM=IDLE.
- req_ready SHALL be 0 during any cycle rst is high.
REQ-026 Reset mid-operation SHALL discard in-flight requests without producing a result.
- The first transfer after reset is granted by priority from requester 0.
REQ-027 res_id and res_lt SHALL read 0 after reset until the first result.

Structure
REQ-028 Package lt_cmp_pkg SHALL hold:
- parameter defaults NREQ and W;
- the FSM state enum (IDLE, RUN, STALL);
- a typedef for the stage record (valid, id, a, b, signed flag).
REQ-029 Extension and compare SHALL live in the sub-module lt_cmp_core, purely combinational: extend then compare.
- The scheduler instantiates it once, with S1/S2 registers around it.

Verification
REQ-030 Single request: W=16, req0 a=16'hFFFF, awidth=4, b=16'h0001, bwidth=2, signed=1 (a=-1, b=1) -> res_lt=1, res_id=0, res_valid exactly 2 cycles after the transfer.
REQ-031 Same operands with signed=0 (a=15, b=1) -> res_lt=0. Also a=9'h100, b=9'h0FF, widths 9, unsigned -> 0; same with signed -> 1.
REQ-032 All four requesters continuously valid -> grants in order 0,1,2,3,0,..., one transfer per cycle, res_id matches grant order.
REQ-033 Hold res_ready=0 for 5 cycles with 2 in flight:
- res_valid, res_id and res_lt stay stable;
- req_ready stays 0 after S1 fills;
- on release, both results are delivered on consecutive cycles.
REQ-034 Assert rst for 1 cycle with S1 and S2 full -> no res_valid afterwards from those requests; next grant goes to req0 when all are valid.
REQ-035 Width edge cases: width 0 and width 31 behave as width 16 (a=16'h8000, b=0, signed -> 1); width 1 signed a=1 is -1 (a=1, b=0 -> 1).

Source files
------------

// File: rtl/lt_cmp_pkg.sv
// Shared types for the shared less-than comparator scheduler.
// Holds parameter defaults, the scheduler state enum and the stage record.
package lt_cmp_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 16;
  localparam int DEF_IW   = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } sched_st_t;

  // Record sized by the package defaults.
  typedef struct packed {
    logic              valid;
    logic [DEF_IW-1:0] id;
    logic [DEF_W-1:0]  a;
    logic [DEF_W-1:0]  b;
    logic              sgn;
  } stage_t;

endpackage

// File: rtl/lt_cmp_core.sv
// Combinational extend-then-compare: mask each operand to its width,
// sign/zero extend to W bits, then a < b (signed or unsigned).
// Ports: a, b, awidth, bwidth, sgn in; lt out.
module lt_cmp_core #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [4:0]   awidth,
  input  logic [4:0]   bwidth,
  input  logic         sgn,
  output logic         lt
);

  // Width 0 or anything above W means the full W bits.
  function automatic logic [W-1:0] ext(
    input logic [W-1:0] v,
    input logic [4:0]   w,
    input logic         s
  );
    int n;
    logic [W-1:0] m;
    logic sb;
    n  = (w == 5'd0 || int'(w) > W) ? W : int'(w);
    m  = {W{1'b1}} >> (W - n);
    sb = |(v & (W'(1) << (n - 1)));
    return (s && sb) ? (v | ~m) : (v & m);
  endfunction

  logic [W-1:0] xa;
  logic [W-1:0] xb;

  assign xa = ext(a, awidth, sgn);
  assign xb = ext(b, bwidth, sgn);
  assign lt = sgn ? ($signed(xa) < $signed(xb))
                  : (xa < xb);

endmodule

// File: rtl/lt_cmp_sched.sv
// Round-robin scheduler sharing one comparator among NREQ requesters.
// Ports: clk, rst, req_* (valid/ready, operands, widths, signed),
// res_* (valid/ready, id, lt). Two stages: S1 operands, S2 result.
module lt_cmp_sched
  import lt_cmp_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][W-1:0]   req_a,
  input  logic [NREQ-1:0][W-1:0]   req_b,
  input  logic [NREQ-1:0][4:0]     req_awidth,
  input  logic [NREQ-1:0][4:0]     req_bwidth,
  input  logic [NREQ-1:0]          req_signed,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IW-1:0]            res_id,
  output logic                     res_lt
);

  stage_t      s1_q;
  logic [4:0]  s1_aw;
  logic [4:0]  s1_bw;
  logic        s2_v;
  logic [IW-1:0] s2_id;
  logic        s2_lt;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_id;
  logic          gnt_ok;
  logic          s2_free;
  logic          s2_load;
  logic          s1_free;
  logic          take;
  logic          core_lt;
  logic          s1_nv;
  logic          s2_nv;
  sched_st_t     st;
  sched_st_t     st_nx;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j      = 0;
    gnt_ok = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_ok && req_valid[IW'(j)]) begin
        gnt_ok = 1'b1;
        gnt_id = IW'(j);
      end
    end
  end

  assign s2_free = !s2_v || res_ready;
  assign s2_load = s1_q.valid && s2_free;
  assign s1_free = !s1_q.valid || s2_load;
  assign take    = gnt_ok && s1_free && !rst;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[gnt_id] = 1'b1;
  end

  lt_cmp_core #(.W(W)) u_core (
    .a      (W'(s1_q.a)),
    .b      (W'(s1_q.b)),
    .awidth (s1_aw),
    .bwidth (s1_bw),
    .sgn    (s1_q.sgn),
    .lt     (core_lt)
  );

  assign s1_nv = take || (s1_q.valid && !s2_load);
  assign s2_nv = s2_load || (s2_v && !res_ready);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:  if (take) st_nx = RUN;
      RUN: begin
        if (s2_v && !res_ready)
          st_nx = STALL;
        else if (!s1_nv && !s2_nv && !take)
          st_nx = IDLE;
      end
      STALL: if (res_ready) st_nx = RUN;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s1_aw  <= '0;
      s1_bw  <= '0;
      s2_v   <= 1'b0;
      s2_id  <= '0;
      s2_lt  <= 1'b0;
      rr_ptr <= '0;
      st     <= IDLE;
    end else begin
      st <= st_nx;
      if (take) begin
        s1_q.valid <= 1'b1;
        s1_q.id    <= DEF_IW'(gnt_id);
        s1_q.a     <= DEF_W'(req_a[gnt_id]);
        s1_q.b     <= DEF_W'(req_b[gnt_id]);
        s1_q.sgn   <= req_signed[gnt_id];
        s1_aw      <= req_awidth[gnt_id];
        s1_bw      <= req_bwidth[gnt_id];
        rr_ptr     <= (gnt_id == IW'(NREQ - 1))
                      ? '0 : gnt_id + 1'b1;
      end else if (s2_load) begin
        s1_q.valid <= 1'b0;
      end
      if (s2_load) begin
        s2_v  <= 1'b1;
        s2_id <= IW'(s1_q.id);
        s2_lt <= core_lt;
      end else if (res_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign res_valid = s2_v;
  assign res_id    = s2_id;
  assign res_lt    = s2_lt;

endmodule
